dft_stream: RTL and testbench

- Parametrised, streaming, time-multiplexed N-point complex DFT engine.
- Successor to the flat 16-input combinational DFT: samples arrive serially on a valid/ready port, and bins leave serially on a valid/ready port.
- Adds complex input, a run-time inverse mode, and back-pressure.
- One shared complex MAC evaluates each bin over N cycles.

---
 rtl/dft_stream_if.sv | 41 ++++
 rtl/dft_stream.sv | 190 +++++++++++++++++++
 tb/tb_dft_stream.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dft_stream_if.sv
// Stream interface for dft_stream: sample input port and bin output port.
//
// Handshake rule for both ports: a transfer happens on a rising clk edge
// where valid and ready are both high. A source holds valid and its data
// stable until that edge. A sink may raise or drop ready at any time. Ready
// is never derived combinationally from valid.
interface dft_stream_if #(
  parameter int N      = 16,
  parameter int DATA_W = 6,
  parameter int TW_W   = 8
);
  localparam int LOG2N = $clog2(N);
  localparam int ACC_W = DATA_W + TW_W + 1 + LOG2N;

  // sample input side
  logic                     mode_inv;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_re;
  logic signed [DATA_W-1:0] in_im;

  // bin output side
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_re;
  logic signed [ACC_W-1:0]  out_im;
  logic [LOG2N-1:0]         out_bin;
  logic                     out_last;

  // producer of samples / consumer of bins
  modport master (
    output mode_inv, in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_bin, out_last
  );

  // the transform engine
  modport slave (
    input  mode_inv, in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_bin, out_last
  );
endinterface

// File: rtl/dft_stream.sv
// Streaming, time-multiplexed N-point complex DFT.
// Loads N samples, then evaluates each bin k with one shared complex MAC
// over N cycles (phase ph = k*n mod N indexes the twiddle ROM), presents
// the bin, and moves on to k+1. Inverse mode flips the sign of the sine
// term (no 1/N scaling). Accumulators are wide enough that no bit is lost.
module dft_stream #(
  parameter int N      = 16,
  parameter int DATA_W = 6,
  parameter int TW_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  dft_stream_if.slave bus,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam int  LOG2N  = $clog2(N);
  localparam int  ACC_W  = DATA_W + TW_W + 1 + LOG2N;
  localparam int  PROD_W = DATA_W + TW_W;
  localparam int  SCALE  = (1 << (TW_W - 1)) - 1;
  localparam real PI     = 3.14159265358979323846;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state, state_next;

  // control counters and datapath registers
  logic [LOG2N-1:0]         wr_cnt;
  logic [LOG2N-1:0]         n_cnt;
  logic [LOG2N-1:0]         k_cnt;
  logic [LOG2N-1:0]         ph;
  logic                     inv_q;
  logic signed [ACC_W-1:0]  acc_re;
  logic signed [ACC_W-1:0]  acc_im;

  // sample buffer, deliberately left out of reset
  logic signed [DATA_W-1:0] buf_re [N];
  logic signed [DATA_W-1:0] buf_im [N];

  // twiddle ROM: round(S*cos(2*pi*i/N)) and round(S*sin(2*pi*i/N))
  logic signed [TW_W-1:0]   tw_c [N];
  logic signed [TW_W-1:0]   tw_s [N];

  for (genvar g = 0; g < N; g++) begin : g_rom
    localparam real ANG  = 2.0 * PI * g / N;
    localparam real CV_R = SCALE * $cos(ANG);
    localparam real SV_R = SCALE * $sin(ANG);
    localparam int  CV   = (CV_R >= 0.0) ? $rtoi(CV_R + 0.5) : -$rtoi(0.5 - CV_R);
    localparam int  SV   = (SV_R >= 0.0) ? $rtoi(SV_R + 0.5) : -$rtoi(0.5 - SV_R);
    assign tw_c[g] = TW_W'(CV);
    assign tw_s[g] = TW_W'(SV);
  end

  // handshake strobes from the control process
  logic load_fire;
  logic out_fire;
  logic in_ready_c;
  logic out_valid_c;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= state_next;
  end

  // next-state logic and handshake outputs
  always_comb begin
    state_next  = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy        = 1'b0;
    load_fire   = 1'b0;
    out_fire    = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready_c = 1'b1;
        load_fire  = bus.in_valid;
        if (load_fire && (wr_cnt == LAST)) state_next = S_MAC;
      end
      S_MAC: begin
        busy = 1'b1;
        if (n_cnt == LAST) state_next = S_OUT;
      end
      S_OUT: begin
        busy        = 1'b1;
        out_valid_c = 1'b1;
        out_fire    = bus.out_ready;
        if (out_fire) state_next = (k_cnt == LAST) ? S_LOAD : S_MAC;
      end
      default: state_next = S_LOAD;
    endcase
  end

  // one complex MAC term: x[n] * W^(k*n), sign of the sine part set by mode
  logic signed [DATA_W-1:0] xr, xi;
  logic signed [TW_W-1:0]   cw, sw;
  logic signed [PROD_W-1:0] p_rc, p_is, p_ic, p_rs;
  logic signed [ACC_W-1:0]  term_re, term_im;

  // operand fetch and full-precision products
  always_comb begin
    xr      = buf_re[n_cnt];
    xi      = buf_im[n_cnt];
    cw      = tw_c[ph];
    sw      = tw_s[ph];
    p_rc    = PROD_W'(xr) * PROD_W'(cw);
    p_is    = PROD_W'(xi) * PROD_W'(sw);
    p_ic    = PROD_W'(xi) * PROD_W'(cw);
    p_rs    = PROD_W'(xr) * PROD_W'(sw);
    term_re = '0;
    term_im = '0;
    if (inv_q) begin
      term_re = ACC_W'(p_rc) - ACC_W'(p_is);
      term_im = ACC_W'(p_ic) + ACC_W'(p_rs);
    end else begin
      term_re = ACC_W'(p_rc) + ACC_W'(p_is);
      term_im = ACC_W'(p_ic) - ACC_W'(p_rs);
    end
  end

  // sample capture into the buffer
  always_ff @(posedge clk) begin
    if (load_fire) begin
      buf_re[wr_cnt] <= bus.in_re;
      buf_im[wr_cnt] <= bus.in_im;
    end
  end

  // counters, mode latch and accumulators
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      n_cnt  <= '0;
      k_cnt  <= '0;
      ph     <= '0;
      inv_q  <= 1'b0;
      acc_re <= '0;
      acc_im <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (load_fire) begin
            wr_cnt <= wr_cnt + LOG2N'(1);
            if (wr_cnt == '0) inv_q <= bus.mode_inv;
            if (wr_cnt == LAST) begin
              k_cnt  <= '0;
              n_cnt  <= '0;
              ph     <= '0;
              acc_re <= '0;
              acc_im <= '0;
            end
          end
        end
        S_MAC: begin
          acc_re <= acc_re + term_re;
          acc_im <= acc_im + term_im;
          // modulo-N wrap comes for free from the LOG2N-bit width
          ph     <= ph + k_cnt;
          n_cnt  <= n_cnt + LOG2N'(1);
        end
        S_OUT: begin
          if (out_fire && (k_cnt != LAST)) begin
            k_cnt  <= k_cnt + LOG2N'(1);
            n_cnt  <= '0;
            ph     <= '0;
            acc_re <= '0;
            acc_im <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // output port drive: bin data comes straight from the accumulators
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_re    = acc_re;
  assign bus.out_im    = acc_im;
  assign bus.out_bin   = k_cnt;
  assign bus.out_last  = (state == S_OUT) && (k_cnt == LAST);
  assign state_dbg     = state;

endmodule

// File: tb/tb_dft_stream.sv
// Testbench for dft_stream: directed frames from the test plan plus
// randomized frames, checked against a direct-summation DFT model.
module tb_dft_stream;

  localparam int  N      = 16;
  localparam int  DATA_W = 6;
  localparam int  TW_W   = 8;
  localparam int  LOG2N  = $clog2(N);
  localparam int  ACC_W  = DATA_W + TW_W + 1 + LOG2N;
  localparam int  SCALE  = (1 << (TW_W - 1)) - 1;
  localparam int  GUARD  = 2000;

  // clock / reset
  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [1:0] state_dbg;

  dft_stream_if #(.N(N), .DATA_W(DATA_W), .TW_W(TW_W)) bus ();

  dft_stream #(.N(N), .DATA_W(DATA_W), .TW_W(TW_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [2*ACC_W-1:0] exp_q[$];
  int tests_run;
  int tests_failed;
  int tc [N];
  int ts [N];
  int xr_a [N];
  int xi_a [N];
  int got_re [N];
  int got_im [N];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic build_twiddles();
    for (int i = 0; i < N; i++) begin
      real a, cv, sv;
      a  = 2.0 * 3.14159265358979323846 * i / N;
      cv = SCALE * $cos(a);
      sv = SCALE * $sin(a);
      tc[i] = (cv >= 0.0) ? $rtoi(cv + 0.5) : -$rtoi(0.5 - cv);
      ts[i] = (sv >= 0.0) ? $rtoi(sv + 0.5) : -$rtoi(0.5 - sv);
    end
  endtask

  // direct DFT: X[k] = sum x[n] * (cos -/+ j sin)(2*pi*k*n/N) scaled by S
  task automatic push_expected(input bit inv);
    for (int k = 0; k < N; k++) begin
      longint re, im;
      re = 0;
      im = 0;
      for (int n = 0; n < N; n++) begin
        int p;
        p = (k * n) % N;
        if (!inv) begin
          re += xr_a[n] * tc[p] + xi_a[n] * ts[p];
          im += xi_a[n] * tc[p] - xr_a[n] * ts[p];
        end else begin
          re += xr_a[n] * tc[p] - xi_a[n] * ts[p];
          im += xi_a[n] * tc[p] + xr_a[n] * ts[p];
        end
      end
      exp_q.push_back({ACC_W'(re), ACC_W'(im)});
    end
  endtask

  task automatic clear_samples();
    for (int i = 0; i < N; i++) begin
      xr_a[i] = 0;
      xi_a[i] = 0;
    end
  endtask

  task automatic random_samples();
    for (int i = 0; i < N; i++) begin
      xr_a[i] = int'($urandom_range(0, 63)) - 32;
      xi_a[i] = int'($urandom_range(0, 63)) - 32;
    end
  endtask

  // driver: first `count` samples; mode_inv toggles after sample 0
  task automatic send_frame(input bit inv, input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      int guard;
      if (gaps) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
      end
      bus.in_valid = 1'b1;
      bus.in_re    = DATA_W'(xr_a[i]);
      bus.in_im    = DATA_W'(xi_a[i]);
      bus.mode_inv = (i == 0) ? inv : ~inv;
      guard = 0;
      while (!bus.in_ready && guard < GUARD) begin
        step();
        guard++;
      end
      if (guard >= GUARD) begin
        tests_run++;
        tests_failed++;
        $display("FAIL send_timeout sample %0d: in_ready=%0b, required 1", i, bus.in_ready);
        bus.in_valid = 1'b0;
        return;
      end
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  // monitor: collect N bins, compare against exp_q; optional 5-cycle stall on one bin
  task automatic collect_frame(input bit bp, input int stall_bin, input string name);
    for (int b = 0; b < N; b++) begin
      int guard;
      logic [2*ACC_W-1:0] exp;
      if (b == stall_bin) begin
        logic signed [ACC_W-1:0] s_re, s_im;
        logic [LOG2N-1:0] s_bin;
        bit stable;
        bus.out_ready = 1'b0;
        guard = 0;
        while (!bus.out_valid && guard < GUARD) begin
          step();
          guard++;
        end
        s_re = bus.out_re;
        s_im = bus.out_im;
        s_bin = bus.out_bin;
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
          step();
          if (bus.out_valid !== 1'b1 || bus.out_re !== s_re || bus.out_im !== s_im ||
              bus.out_bin !== s_bin || bus.in_ready !== 1'b0) stable = 1'b0;
        end
        tests_run++;
        if (!stable) begin
          tests_failed++;
          $display("FAIL %s stall bin %0d: valid=%0b re=%0d im=%0d bin=%0d in_ready=%0b, required held re=%0d im=%0d bin=%0d valid=1 in_ready=0",
                   name, b, bus.out_valid, bus.out_re, bus.out_im, bus.out_bin, bus.in_ready, s_re, s_im, s_bin);
        end
      end
      bus.out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      guard = 0;
      while (!(bus.out_valid && bus.out_ready) && guard < GUARD) begin
        step();
        guard++;
        bus.out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      tests_run++;
      if (guard >= GUARD) begin
        tests_failed++;
        $display("FAIL %s timeout bin %0d: out_valid=%0b, required 1", name, b, bus.out_valid);
        bus.out_ready = 1'b0;
        return;
      end
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      got_re[b] = int'(bus.out_re);
      got_im[b] = int'(bus.out_im);
      if ({bus.out_re, bus.out_im} !== exp || bus.out_bin !== LOG2N'(b) ||
          bus.out_last !== (b == N - 1)) begin
        tests_failed++;
        $display("FAIL %s bin %0d: got re=%0d im=%0d bin=%0d last=%0b, expected re=%0d im=%0d bin=%0d last=%0b",
                 name, b, bus.out_re, bus.out_im, bus.out_bin, bus.out_last,
                 $signed(exp[2*ACC_W-1:ACC_W]), $signed(exp[ACC_W-1:0]), b, (b == N - 1));
      end
      step();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: in_ready=%0b out_valid=%0b busy=%0b last=%0b, required 1 0 0 0",
               bus.in_ready, bus.out_valid, busy, bus.out_last);
    end
    tests_run++;
    if (bus.out_re !== '0 || bus.out_im !== '0 || bus.out_bin !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: re=%0d im=%0d bin=%0d, required 0 0 0", bus.out_re, bus.out_im, bus.out_bin);
    end
  endtask

  task automatic test_dc();
    int lat;
    clear_samples();
    for (int i = 0; i < N; i++) xr_a[i] = 4;
    push_expected(1'b0);
    send_frame(1'b0, N, 1'b0);
    tests_run++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL dc_compute_flags: busy=%0b in_ready=%0b, required 1 0", busy, bus.in_ready);
    end
    lat = 0;
    while (!bus.out_valid && lat < GUARD) begin
      step();
      lat++;
    end
    tests_run++;
    if (lat !== N) begin
      tests_failed++;
      $display("FAIL dc_latency: got %0d cycles, required %0d", lat, N);
    end
    collect_frame(1'b0, -1, "dc");
    tests_run++;
    if (got_re[0] !== 8128 || got_im[0] !== 0) begin
      tests_failed++;
      $display("FAIL dc_bin0: got (%0d,%0d), required (8128,0)", got_re[0], got_im[0]);
    end
  endtask

  task automatic test_impulse();
    clear_samples();
    xr_a[1] = 1;
    push_expected(1'b0);
    send_frame(1'b0, N, 1'b1);
    collect_frame(1'b0, -1, "impulse_fwd");
    tests_run++;
    if (got_re[4] !== 0 || got_im[4] !== -127 || got_re[0] !== 127 || got_im[0] !== 0) begin
      tests_failed++;
      $display("FAIL impulse_fwd_bins: bin4=(%0d,%0d) bin0=(%0d,%0d), required (0,-127) (127,0)",
               got_re[4], got_im[4], got_re[0], got_im[0]);
    end
    push_expected(1'b1);
    send_frame(1'b1, N, 1'b0);
    collect_frame(1'b0, -1, "impulse_inv");
    tests_run++;
    if (got_re[4] !== 0 || got_im[4] !== 127) begin
      tests_failed++;
      $display("FAIL impulse_inv_bin4: got (%0d,%0d), required (0,127)", got_re[4], got_im[4]);
    end
  endtask

  task automatic test_alternating();
    bit ok;
    clear_samples();
    for (int i = 0; i < N; i++) xr_a[i] = (i % 2 == 0) ? 1 : -1;
    push_expected(1'b0);
    send_frame(1'b0, N, 1'b0);
    collect_frame(1'b1, -1, "alternating");
    ok = (got_re[8] == 2032) && (got_im[8] == 0);
    for (int b = 0; b < N; b++)
      if (b != 8 && (got_re[b] != 0 || got_im[b] != 0)) ok = 1'b0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL alternating_bins: bin8=(%0d,%0d), required (2032,0) with all others zero",
               got_re[8], got_im[8]);
    end
  endtask

  task automatic test_back_pressure();
    bit ok;
    random_samples();
    push_expected(1'b0);
    send_frame(1'b0, N, 1'b0);
    // junk samples offered mid-compute must be ignored
    ok = 1'b1;
    bus.in_valid = 1'b1;
    for (int c = 0; c < N / 2; c++) begin
      bus.in_re = DATA_W'($urandom_range(0, 63));
      bus.in_im = DATA_W'($urandom_range(0, 63));
      if (bus.in_ready !== 1'b0) ok = 1'b0;
      step();
    end
    bus.in_valid = 1'b0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL bp_in_ready_compute: in_ready=%0b, required 0", bus.in_ready);
    end
    collect_frame(1'b0, 3, "back_pressure");
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      bit inv;
      inv = 1'($urandom_range(0, 1));
      random_samples();
      push_expected(inv);
      send_frame(inv, N, 1'b1);
      collect_frame(1'b1, -1, inv ? "random_inv" : "random_fwd");
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      random_samples();
      push_expected(1'(f));
      send_frame(1'(f), N, 1'b0);
      collect_frame(1'b0, -1, "back_to_back");
    end
  endtask

  task automatic test_mid_reset_load();
    bit ok;
    random_samples();
    send_frame(1'b1, 7, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    tests_run++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_load_flags: in_ready=%0b busy=%0b out_valid=%0b, required 1 0 0",
               bus.in_ready, busy, bus.out_valid);
    end
    clear_samples();
    xr_a[0] = 5;
    push_expected(1'b0);
    send_frame(1'b0, N, 1'b0);
    collect_frame(1'b0, -1, "reset_load_impulse");
    ok = 1'b1;
    for (int b = 0; b < N; b++)
      if (got_re[b] != 635 || got_im[b] != 0) ok = 1'b0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL reset_load_bins: bin0=(%0d,%0d), required all bins (635,0)", got_re[0], got_im[0]);
    end
  endtask

  task automatic test_mid_reset_out();
    int guard;
    random_samples();
    send_frame(1'b0, N, 1'b0);
    bus.out_ready = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < GUARD) begin
      step();
      guard++;
    end
    rst_n = 1'b0;
    step();
    tests_run++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_out_flags: out_valid=%0b busy=%0b in_ready=%0b, required 0 0 1",
               bus.out_valid, busy, bus.in_ready);
    end
    rst_n = 1'b1;
    step();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_spurious: out_valid=%0b, required 0", bus.out_valid);
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.mode_inv  = 1'b0;
    bus.out_ready = 1'b0;
    build_twiddles();
    test_reset();
    test_dc();
    test_impulse();
    test_alternating();
    test_back_pressure();
    test_random();
    test_back_to_back();
    test_mid_reset_load();
    test_mid_reset_out();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
